// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: aligns and extends loads, turns byte/halfword
// stores into a read-modify-write on a word-wide data memory.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  stall,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned
);

  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] merge_reg, merge_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  rdata_valid_reg, rdata_valid_next;
  logic                  misaligned_reg, misaligned_next;

  logic                  is_misaligned;
  logic [LANES-1:0]      lane_sel;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign mem_addr = {2'b00, req_addr[ADDR_WIDTH-1:2]};

  assign is_misaligned = (req_size == 2'b11) ||
                         ((req_size == 2'b01) && req_addr[0]) ||
                         ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    lane_sel = '0;
    case (req_size)
      2'b00:   lane_sel[req_addr[1:0]] = 1'b1;
      2'b01:   lane_sel = req_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = '1;
    endcase
  end

  // Each lane takes the store byte that lands on it: byte stores replicate
  // wdata[7:0], halfword stores use wdata[15:0] on either half.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] store_byte;
      assign store_byte = (req_size == 2'b00) ? req_wdata[7:0]
                                              : req_wdata[8*(gi%2) +: 8];
      assign merged_word[8*gi +: 8] = lane_sel[gi] ? store_byte
                                                   : merge_reg[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
  assign ld_half = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (req_size)
      2'b00: load_data = req_unsigned ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                      : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      2'b01: load_data = req_unsigned ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                      : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    merge_next       = merge_reg;
    rdata_next       = rdata_reg;
    rdata_valid_next = 1'b0;
    misaligned_next  = 1'b0;
    stall            = 1'b0;
    mem_we           = 1'b0;
    mem_wdata        = req_wdata;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned) begin
            misaligned_next = 1'b1;
            rdata_next      = '0;
          end else if (!req_we) begin
            rdata_next       = load_data;
            rdata_valid_next = 1'b1;
          end else if (req_size == 2'b10) begin
            mem_we = 1'b1;
          end else begin
            // Capture the old word now; the merged write goes out next cycle.
            merge_next = mem_rdata;
            stall      = 1'b1;
            state_next = MERGE;
          end
        end
      end
      MERGE: begin
        mem_we     = 1'b1;
        mem_wdata  = merged_word;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      stall  = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      merge_reg       <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      misaligned_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      merge_reg       <= merge_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      misaligned_reg  <= misaligned_next;
    end
  end

  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps followed by random traffic,
// checked against a byte-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic        mem_we, stall, rdata_valid, misaligned;

  logic [31:0] mem [16];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  logic [7:0]  ref_mem [64];
  int          checks = 0;
  int          failures = 0;
  logic        exp_valid = 1'b0;
  logic        exp_mis = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .stall(stall),
    .rdata_valid(rdata_valid), .rdata(rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'h0, ref_mem[a]};
        if (!uns && v[7]) v = v - 32'd256;
      end
      2'd1: begin
        v = {16'h0, ref_mem[a+1], ref_mem[a]};
        if (!uns && v[15]) v = v - 32'd65536;
      end
      default: v = ref_word(a / 4);
    endcase
    return v;
  endfunction

  task automatic check_pulses();
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_valid));
    chk("misaligned", 32'(misaligned), 32'(exp_mis));
    chk("rdata", rdata, exp_rdata);
  endtask

  // One request; returns 1 time unit after the edge that ends it.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic mis;
    int   n;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    $display("txn we=%0d size=%0d uns=%0d addr=%0d wdata=0x%08h mis=%0d",
             we, sz, uns, a, wd, mis);
    @(negedge clk);
    check_pulses();
    chk("mem_addr", mem_addr, a / 4);
    if (mis) begin
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_we", 32'(mem_we), 32'd0);
      exp_valid = 1'b0; exp_mis = 1'b1; exp_rdata = 32'h0;
    end else if (!we) begin
      chk("ld_stall", 32'(stall), 32'd0);
      chk("ld_we", 32'(mem_we), 32'd0);
      exp_valid = 1'b1; exp_mis = 1'b0; exp_rdata = ref_load(sz, uns, int'(a[5:0]));
    end else if (sz == 2'd2) begin
      chk("sw_stall", 32'(stall), 32'd0);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_wdata", mem_wdata, wd);
      for (int i = 0; i < 4; i++) ref_mem[int'(a[5:0]) + i] = wd[8*i +: 8];
      exp_valid = 1'b0; exp_mis = 1'b0;
    end else begin
      chk("sub_stall1", 32'(stall), 32'd1);
      chk("sub_we1", 32'(mem_we), 32'd0);
      exp_valid = 1'b0; exp_mis = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) ref_mem[int'(a[5:0]) + i] = wd[8*i +: 8];
      @(negedge clk);
      check_pulses();
      chk("sub_stall2", 32'(stall), 32'd0);
      chk("sub_we2", 32'(mem_we), 32'd1);
      chk("sub_wdata", mem_wdata, ref_word(int'(a[5:2])));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3)); req_addr = $urandom_range(0, 63);
    req_wdata = $urandom;
    @(negedge clk);
    check_pulses();
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_we", 32'(mem_we), 32'd0);
    exp_valid = 1'b0; exp_mis = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; pre_en = 1'b0; pre_idx = 4'd0; pre_data = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd5; req_wdata = 32'h0000_00AB;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'hFF;
    @(posedge clk); #1;
    // Reset phase: a sub-word store is presented but must not stall or write.
    for (int i = 0; i < 16; i++) begin
      pre_en = 1'b1; pre_idx = 4'(i);
      @(negedge clk);
      check_pulses();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
    end
    pre_en = 1'b0; rst = 1'b0;

    // Word store then word load.
    issue(1'b1, 2'd2, 1'b0, 32'd8, 32'h1234_5678);
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    idle();
    // Byte store into all-ones word, then LHU.
    issue(1'b1, 2'd0, 1'b0, 32'd5, 32'h0000_00AB);
    chk("word1_merged", mem[1], 32'hFFFF_ABFF);
    issue(1'b0, 2'd1, 1'b1, 32'd4, 32'h0);
    idle();
    // Extension cases on 0x00008080.
    issue(1'b1, 2'd2, 1'b0, 32'd12, 32'h0000_8080);
    issue(1'b0, 2'd0, 1'b0, 32'd12, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'd12, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'd12, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'd14, 32'h0);
    idle();
    // Misaligned requests.
    issue(1'b1, 2'd1, 1'b0, 32'd3, 32'h0000_BEEF);
    chk("mis_word0", mem[0], ref_word(0));
    issue(1'b0, 2'd2, 1'b0, 32'd2, 32'h0);
    idle();
    // Reset aborting the MERGE cycle of a byte store to addr 0.
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'd0;
    req_wdata = 32'h0000_0012;
    @(negedge clk);
    check_pulses();
    chk("abort_stall1", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_valid = 1'b0; exp_mis = 1'b0; exp_rdata = 32'h0;
    chk("abort_word0", mem[0], ref_word(0));
    idle();
    // Back-to-back LW, LW, SB.
    issue(1'b0, 2'd2, 1'b0, 32'd0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'd4, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'd1, 32'h0000_0055);
    issue(1'b0, 2'd2, 1'b0, 32'd0, 32'h0);
    idle();

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 4) == 0) idle();
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom);
    end
    idle();
    idle();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
